// File: rtl/eth_frame_send.sv
// eth_frame_send: byte-wide Ethernet II transmitter with streamed payload, zero padding and CRC-32 FCS.
// Define ETH_FRAME_SEND_VLAN_EN to add optional 802.1Q tag insertion (i_vlan_tci/i_vlan_en).
module eth_frame_send #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int IFG_LEN      = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    output logic        o_ready,
    input  logic [47:0] i_dst_mac,
    input  logic [47:0] i_src_mac,
    input  logic [15:0] i_ether_type,
`ifdef ETH_FRAME_SEND_VLAN_EN
    input  logic [15:0] i_vlan_tci,
    input  logic        i_vlan_en,
`endif
    input  logic [7:0]  i_pl_data,
    input  logic        i_pl_valid,
    input  logic        i_pl_last,
    output logic        o_pl_ready,
    output logic [7:0]  o_data,
    output logic        o_tx_en,
    output logic        o_tx_er,
    output logic [31:0] o_crc32,
    output logic        o_done,
    output logic        o_trunc
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC,
`ifdef ETH_FRAME_SEND_VLAN_EN
        S_VLAN,
`endif
        S_TYPE, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

`ifdef ETH_FRAME_SEND_VLAN_EN
    localparam int HW = 144;
`else
    localparam int HW = 112;
`endif
    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_LAST = 11'(IFG_LEN);

    state_t        state_q, state_d, src_next;
    logic [10:0]   cnt_q, cnt_d, cnt_inc, min_eff;
    logic [HW-1:0] hdr_q, hdr_d, hdr_load;
    logic [31:0]   crc_q, crc_d;
    logic [7:0]    data_q, data_d;
    logic          tx_en_q, tx_en_d, tx_er_q, tx_er_d;
    logic          done_q, done_d, trunc_q, trunc_d;
    logic          hdr_sel, crc_en;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    // Header fields are flattened into one shift register; DST..TYPE just pop its top byte.
`ifdef ETH_FRAME_SEND_VLAN_EN
    logic vlan_q;
    assign hdr_load = i_vlan_en ? {i_dst_mac, i_src_mac, 16'h8100, i_vlan_tci, i_ether_type}
                                : {i_dst_mac, i_src_mac, i_ether_type, 32'h0};
    assign min_eff  = vlan_q ? 11'(MIN_PAYLOAD - 4) : 11'(MIN_PAYLOAD);
    assign src_next = vlan_q ? S_VLAN : S_TYPE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vlan_q <= 1'b0;
        else if (state_q == S_IDLE && i_start)
            vlan_q <= i_vlan_en;
    end
`else
    assign hdr_load = {i_dst_mac, i_src_mac, i_ether_type};
    assign min_eff  = 11'(MIN_PAYLOAD);
    assign src_next = S_TYPE;
`endif

    assign cnt_inc    = cnt_q + 11'd1;
    assign o_ready    = state_q == S_IDLE;
    assign o_pl_ready = state_q == S_PAY;
    assign o_data     = data_q;
    assign o_tx_en    = tx_en_q;
    assign o_tx_er    = tx_er_q;
    assign o_crc32    = crc_q;
    assign o_done     = done_q;
    assign o_trunc    = trunc_q;

    // Each cycle prepares the byte that appears on o_data after the next edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        hdr_d   = hdr_q;
        crc_d   = crc_q;
        data_d  = 8'h00;
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;
        done_d  = 1'b0;
        trunc_d = 1'b0;
        hdr_sel = 1'b0;
        crc_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 11'd1;
                if (i_start) begin
                    hdr_d   = hdr_load;
                    data_d  = 8'h55;
                    tx_en_d = 1'b1;
                    state_d = PREAMBLE_LEN == 1 ? S_SFD : S_PRE;
                end
            end
            S_PRE: begin
                data_d  = 8'h55;
                tx_en_d = 1'b1;
                if (cnt_q == PRE_LAST) state_d = S_SFD;
            end
            S_SFD: begin
                data_d  = 8'hD5;
                tx_en_d = 1'b1;
                crc_d   = '1;
                cnt_d   = '0;
                state_d = S_DST;
            end
            S_DST: begin
                hdr_sel = 1'b1;
                if (cnt_q == 11'd5) state_d = S_SRC;
            end
            S_SRC: begin
                hdr_sel = 1'b1;
                if (cnt_q == 11'd5) state_d = src_next;
            end
`ifdef ETH_FRAME_SEND_VLAN_EN
            S_VLAN: begin
                hdr_sel = 1'b1;
                if (cnt_q == 11'd3) state_d = S_TYPE;
            end
`endif
            S_TYPE: begin
                hdr_sel = 1'b1;
                if (cnt_q == 11'd1) state_d = S_PAY;
            end
            S_PAY: begin
                tx_en_d = 1'b1;
                if (!i_pl_valid) begin
                    tx_er_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IFG;
                end else begin
                    data_d = i_pl_data;
                    crc_en = 1'b1;
                    if (i_pl_last || cnt_inc == MAX_CNT) begin
                        trunc_d = !i_pl_last;
                        state_d = cnt_inc < min_eff ? S_PAD : S_FCS;
                        cnt_d   = cnt_inc < min_eff ? cnt_inc : '0;
                    end
                end
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                crc_en  = 1'b1;
                if (cnt_inc >= min_eff) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                end
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                data_d  = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == 11'd3) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
            S_IFG: begin
                done_d = cnt_q == '0;
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (hdr_sel) begin
            data_d  = hdr_q[HW-1 -: 8];
            tx_en_d = 1'b1;
            hdr_d   = hdr_q << 8;
            crc_en  = 1'b1;
            if (state_d != state_q) cnt_d = '0;
        end
        if (crc_en) crc_d = crc_byte(crc_q, data_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hdr_q   <= '0;
            crc_q   <= '0;
            data_q  <= '0;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            tx_en_q <= tx_en_d;
            tx_er_q <= tx_er_d;
            done_q  <= done_d;
            trunc_q <= trunc_d;
        end
    end

endmodule

// File: tb/tb_eth_frame_send.sv
// tb_eth_frame_send: randomized frame stimulus against a byte-list reference model of eth_frame_send.
module tb_eth_frame_send;

    localparam int PRE  = 7;
    localparam int MINP = 46;
    localparam int MAXP = 1500;
    localparam int IFG  = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [47:0] i_dst_mac = '0;
    logic [47:0] i_src_mac = '0;
    logic [15:0] i_ether_type = '0;
    logic [15:0] i_vlan_tci = '0;
    logic        i_vlan_en = 1'b0;
    logic [7:0]  i_pl_data = '0;
    logic        i_pl_valid = 1'b0;
    logic        i_pl_last = 1'b0;
    logic        o_ready, o_pl_ready, o_tx_en, o_tx_er, o_done, o_trunc;
    logic [7:0]  o_data;
    logic [31:0] o_crc32;

    eth_frame_send #(
        .PREAMBLE_LEN(PRE), .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP), .IFG_LEN(IFG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_ready(o_ready),
        .i_dst_mac(i_dst_mac), .i_src_mac(i_src_mac), .i_ether_type(i_ether_type),
`ifdef ETH_FRAME_SEND_VLAN_EN
        .i_vlan_tci(i_vlan_tci), .i_vlan_en(i_vlan_en),
`endif
        .i_pl_data(i_pl_data), .i_pl_valid(i_pl_valid), .i_pl_last(i_pl_last),
        .o_pl_ready(o_pl_ready), .o_data(o_data), .o_tx_en(o_tx_en), .o_tx_er(o_tx_er),
        .o_crc32(o_crc32), .o_done(o_done), .o_trunc(o_trunc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [47:0] dst, src;
    logic [15:0] etype, tci;
    logic        vlan = 1'b0;
    logic [7:0]  pl [1600];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC-32 in its textbook MSB-first form, fed each byte LSB first.
    function automatic logic [31:0] crc_msb(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) r = (r << 1) ^ ((r[31] ^ d[b]) ? 32'h04C11DB7 : 32'h0);
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int b = 0; b < 32; b++) r[b] = v[31-b];
        return r;
    endfunction

    task automatic run_frame(input string nm, input int len, input bit last, input int drop,
                             input bit noise, output int txlen);
        logic [7:0]  exp_q[$], rx_q[$];
        logic [31:0] c, exp_crc, fcs, crc_ifg;
        int n, pad, minp, pl_idx, rdy_cyc, er_cnt, er_idx, done_cnt, trunc_cnt, trunc_idx;
        int ifg, k, mm, bad, hlen;
        bit seen, fin, exp_trunc;
        minp = vlan ? MINP - 4 : MINP;
        hlen = vlan ? 18 : 14;
        repeat (PRE) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) exp_q.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(src[8*i +: 8]);
        if (vlan) begin
            exp_q.push_back(8'h81); exp_q.push_back(8'h00);
            exp_q.push_back(tci[15:8]); exp_q.push_back(tci[7:0]);
        end
        exp_q.push_back(etype[15:8]);
        exp_q.push_back(etype[7:0]);
        n = drop >= 0 ? drop : (len > MAXP ? MAXP : len);
        for (int i = 0; i < n; i++) exp_q.push_back(pl[i]);
        exp_crc = '0;
        if (drop >= 0) exp_q.push_back(8'h00);
        else begin
            pad = n < minp ? minp - n : 0;
            repeat (pad) exp_q.push_back(8'h00);
            c = '1;
            for (int i = PRE + 1; i < exp_q.size(); i++) c = crc_msb(c, exp_q[i]);
            exp_crc = bitrev32(c);
            fcs = ~exp_crc;
            for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
        end
        exp_trunc = drop < 0 && len > MAXP;
        k = 0;
        while (!o_ready && k < 200) begin @(negedge clk); k++; end
        check({nm, ":idle"}, 32'(o_ready), 32'd1);
        i_dst_mac = dst; i_src_mac = src; i_ether_type = etype;
        i_vlan_tci = tci; i_vlan_en = vlan;
        i_pl_valid = 1'b0; i_pl_last = 1'b0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check({nm, ":start"}, {30'b0, o_ready, o_tx_en}, 32'd1);
        pl_idx = 0; rdy_cyc = 0; er_cnt = 0; er_idx = -1; done_cnt = 0; trunc_cnt = 0;
        trunc_idx = -1; ifg = 0; seen = 0; fin = 0; crc_ifg = '0;
        for (int cyc = 0; cyc < len + 400 && !fin; cyc++) begin
            if (o_tx_en) begin
                seen = 1;
                if (o_tx_er) begin er_cnt++; er_idx = rx_q.size(); end
                if (o_trunc) begin trunc_cnt++; trunc_idx = rx_q.size(); end
                rx_q.push_back(o_data);
            end else if (seen) begin
                if (o_ready) fin = 1;
                else begin
                    if (ifg == 0) crc_ifg = o_crc32;
                    ifg++;
                end
            end
            if (o_done) done_cnt++;
            if (o_pl_ready) rdy_cyc++;
            if (!fin) begin
                i_start = noise && o_pl_ready;
                i_pl_valid = pl_idx < len && pl_idx != drop;
                i_pl_data = pl[pl_idx < 1600 ? pl_idx : 0];
                i_pl_last = last && pl_idx == len - 1;
                if (o_pl_ready && i_pl_valid) pl_idx++;
                @(negedge clk);
            end
        end
        i_start = 1'b0; i_pl_valid = 1'b0; i_pl_last = 1'b0;
        check({nm, ":finish"}, 32'(fin), 32'd1);
        txlen = rx_q.size();
        check({nm, ":len"}, rx_q.size(), exp_q.size());
        mm = -1;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (mm < 0 && rx_q[i] !== exp_q[i]) mm = i;
        check({nm, ":first_bad_byte"}, mm, -1);
        check({nm, ":tx_er"}, er_cnt, 32'(drop >= 0));
        if (drop >= 0) check({nm, ":er_pos"}, er_idx, exp_q.size() - 1);
        check({nm, ":done"}, done_cnt, 1);
        check({nm, ":ifg"}, ifg, IFG);
        check({nm, ":trunc"}, trunc_cnt, 32'(exp_trunc));
        if (exp_trunc) check({nm, ":trunc_pos"}, trunc_idx, PRE + 1 + hlen + MAXP - 1);
        check({nm, ":pl_ready"}, rdy_cyc, drop >= 0 ? drop + 1 : n);
        if (drop < 0) begin
            c = '1;
            for (int i = PRE + 1; i < rx_q.size(); i++) c = crc_msb(c, rx_q[i]);
            check({nm, ":residue"}, c, 32'hC704DD7B);
            check({nm, ":crc_out"}, crc_ifg, exp_crc);
        end
        bad = 0;
        repeat (3) begin @(negedge clk); if (o_tx_en) bad++; end
        check({nm, ":no_restart"}, bad, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int txlen, len, drop;
        repeat (3) @(negedge clk);
        check("rst_tx_en", 32'(o_tx_en), 0);
        check("rst_tx_er", 32'(o_tx_er), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_crc", o_crc32, 0);
        check("rst_flags", {29'b0, o_done, o_trunc, o_pl_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(o_ready), 1);

        dst = 48'hFFFF_FFFF_FFFF; src = 48'h0011_2233_4455; etype = 16'h0806; tci = '0;
        for (int i = 0; i < 28; i++) pl[i] = 8'(i + 1);
        run_frame("arp", 28, 1, -1, 0, txlen);
        check("arp_72", txlen, 72);

        dst = {$urandom, $urandom}; src = {$urandom, $urandom}; etype = 16'h0800;
        for (int i = 0; i < 100; i++) pl[i] = 8'($urandom);
        run_frame("p100", 100, 1, -1, 0, txlen);
        check("p100_126", txlen, 126);

        for (int i = 0; i < 40; i++) pl[i] = 8'($urandom);
        run_frame("underrun", 40, 1, 10, 0, txlen);

        for (int i = 0; i < 1600; i++) pl[i] = 8'($urandom);
        run_frame("trunc", 1600, 0, -1, 0, txlen);

        // Reset while the destination MAC is on the wire.
        dst = {$urandom, $urandom};
        i_dst_mac = dst; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_tx_en_before", 32'(o_tx_en), 1);
        #2 rst_n = 1'b0;
        #1 check("mid_tx_en_async", 32'(o_tx_en), 0);
        check("mid_tx_er_async", 32'(o_tx_er), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_ready", 32'(o_ready), 1);
        for (int i = 0; i < 60; i++) pl[i] = 8'($urandom);
        run_frame("after_rst", 60, 1, -1, 1, txlen);

        for (int f = 0; f < 6; f++) begin
            dst = {$urandom, $urandom}; src = {$urandom, $urandom}; etype = 16'($urandom);
            len = $urandom_range(1, 120);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
            run_frame($sformatf("rand%0d", f), len, 1, drop, f[0], txlen);
        end

`ifdef ETH_FRAME_SEND_VLAN_EN
        vlan = 1'b1; tci = 16'h0064;
        for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
        run_frame("vlan", 10, 1, -1, 0, txlen);
        check("vlan_72", txlen, 72);
        vlan = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_frame_send.md
Name: eth_frame_send

Overview:
- Parametrised, byte-wide (GMII-style) Ethernet II frame transmitter.
- Generalises the fixed-format ARP sender:
  - arbitrary EtherType;
  - streamed payload of variable length via valid/ready/last;
  - parametrised preamble, minimum-frame padding, maximum payload and inter-frame gap;
  - inline CRC-32 FCS generation.
- Sits between protocol frame builders (ARP, IPv4/UDP) and the MAC/PHY byte interface.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD (0xD5); legal 1..15
- MIN_PAYLOAD, 46, payload bytes below which zero padding is appended
- MAX_PAYLOAD, 1500, payload bytes after which the frame is truncated
- IFG_LEN, 12, idle cycles (o_tx_en low) after the FCS before o_ready returns; legal 1..63

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request; sampled only in IDLE
- o_ready  out  1  high in IDLE only
- i_dst_mac  in  48  destination MAC, latched on accepted start
- i_src_mac  in  48  source MAC, latched on accepted start
- i_ether_type  in  16  EtherType, latched on accepted start
- i_pl_data  in  8  payload byte
- i_pl_valid  in  1  payload byte valid
- i_pl_last  in  1  marks final payload byte
- o_pl_ready  out  1  payload byte consumed this cycle when high together with i_pl_valid
- o_data  out  8  transmit byte
- o_tx_en  out  1  transmit enable
- o_tx_er  out  1  transmit error (underrun abort)
- o_crc32  out  32  running CRC register (pre-inversion)
- o_done  out  1  one-cycle pulse on entry to IFG
- o_trunc  out  1  one-cycle pulse when the MAX_PAYLOAD truncation occurs

Behaviour:
- Reset: every output 0 except o_ready; state goes to IDLE, so o_ready=1 on the first clock after reset release.
- Reset mid-frame: o_tx_en/o_tx_er drop asynchronously. The frame is not completed.
- States, in order:
  - IDLE
  - PREAMBLE (PREAMBLE_LEN bytes)
  - SFD (1)
  - DST (6)
  - SRC (6)
  - [VLAN (4)]
  - TYPE (2)
  - PAYLOAD (variable)
  - PAD (0..MIN_PAYLOAD-1)
  - FCS (4)
  - IFG (IFG_LEN)
  - back to IDLE
- Multi-byte fields are sent MSB byte first.
- IDLE:
  - If i_start=1 at edge N: latch header fields, o_ready=0 at N+1, o_tx_en=1 with first 0x55 at N+1.
  - i_start outside IDLE is ignored; no queuing.
- o_tx_en=1 from PREAMBLE through the last FCS byte; 0 in IDLE/IFG, where o_data=0x00.
- CRC-32:
  - Polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF.
  - Cleared at SFD.
  - Updated on every byte of DST..PAD inclusive.
  - FCS bytes are ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24], in that order.
  - o_crc32 holds its value through FCS/IFG until the next SFD.
- PAYLOAD:
  - o_pl_ready=1 every cycle in PAYLOAD; one byte per cycle; o_data=i_pl_data combinationally registered (1-cycle pipeline from handshake to o_data).
  - Byte with i_pl_last=1 ends the payload. Next state is PAD if count<MIN_PAYLOAD, else FCS.
  - Payload counter is 11 bits. The byte at count==MAX_PAYLOAD is treated as last: o_trunc pulses, and further bytes are not accepted (o_pl_ready=0).
- Underrun (i_pl_valid=0 while o_pl_ready=1):
  - Emit one byte with o_tx_en=1, o_tx_er=1, o_data=0x00.
  - Skip PAD/FCS and go to IFG.
  - o_done still pulses.
  - Upstream must drain its remaining payload itself.
- Zero-length payload is not representable: the first byte is always sent. The minimum frame is PREAMBLE+SFD+14+MIN_PAYLOAD+4 bytes.
- PAD sends 0x00 until total payload+pad == MIN_PAYLOAD.
- Simultaneous i_pl_last and truncation on the same byte: only the last handling applies; o_trunc=0.

Optional Feature:
- Macro: ETH_FRAME_SEND_VLAN_EN.
- When defined:
  - Adds port i_vlan_tci (in, 16) and port i_vlan_en (in, 1), both latched on start.
  - If i_vlan_en=1, a VLAN state after SRC sends 0x8100 then the TCI (MSB first).
  - MIN_PAYLOAD is reduced by 4 for that frame (min frame stays 64 bytes without preamble).
- When undefined: ports are absent, the VLAN state does not exist, and the frame is untagged.

Test Plan:
- Reset, then i_start with dst=FF:FF:FF:FF:FF:FF, src=00:11:22:33:44:55, type=0x0806, 28-byte payload 0x01..0x1C:
  - o_tx_en high for 72 cycles.
  - Bytes: 7×0x55, 0xD5, dst, src, 08 06, payload, 18×0x00, FCS.
  - CRC over DST..FCS gives residue 0xC704DD7B.
  - o_done pulses; o_ready=1 exactly IFG_LEN cycles after o_tx_en falls.
- 100-byte payload, i_pl_valid always 1: no pad; o_tx_en high for 8+14+100+4=126 cycles; o_pl_ready high for exactly 100 cycles.
- i_pl_valid dropped at payload byte 10:
  - One cycle with o_tx_er=1, o_data=0x00.
  - Then o_tx_en=0, no FCS emitted, o_done pulse.
- 1600-byte stream with no last (MAX_PAYLOAD=1500): o_trunc pulses on byte 1500; o_pl_ready=0 afterwards; a valid FCS follows.
- Negate rst_n during DST:
  - o_tx_en=0 immediately.
  - After release o_ready=1; a new i_start sends a complete correct frame.
  - i_start pulses during PAYLOAD are ignored.
- With ETH_FRAME_SEND_VLAN_EN, i_vlan_en=1, TCI=0x0064, 10-byte payload:
  - Bytes after SRC are 81 00 00 64 then type.
  - Pad = 32 bytes (payload+pad = 42).
  - o_tx_en high for 72 cycles.
